// File: rtl/uart_port_ctrl.sv
// rtl/uart_port_ctrl.sv - memory-mapped port between a MEM-stage request and a byte-wide serial chip
//
// Purpose: decodes two register addresses (data, status) out of the load/store
// stream, stalls the pipeline while an access is in flight, and sequences the
// serial chip's rdn/wrn strobes and shared data bus around it.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   req_read, req_write      MEM-stage load/store request, held until ack
//   addr, wdata              access address and store data (low byte sent)
//   sel, busy                combinational decode hit and pipeline stall
//   ack, rdata               one-cycle completion pulse and held load result
//   bus_in, bus_out, bus_oe  shared data bus towards the serial chip
//   data_ready, tbre, tsre   serial chip status inputs
//   rdn, wrn                 active-low read / write strobes
module uart_port_ctrl #(
    parameter logic [15:0] DATA_ADDR = 16'hBF00,
    parameter logic [15:0] STAT_ADDR = 16'hBF01,
    parameter int          RD_HOLD   = 2,
    parameter int          WR_PULSE  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        sel,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        busy,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn
);

    localparam int CNT_W = 8;

    typedef enum logic [3:0] {
        IDLE, STAT, RD_WAIT, RD_LOW, WR_SETUP, WR_LOW, WR_HOLD, WR_TBRE, WR_TSRE, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        rdata_q, rdata_d;
    logic [7:0]         bus_out_q, bus_out_d;

    logic hit_data, hit_stat;
    logic wdata_unused;

    assign hit_data     = (addr == DATA_ADDR);
    assign hit_stat     = (addr == STAT_ADDR);
    assign wdata_unused = ^wdata[15:8];

    assign sel  = (req_read | req_write) & (hit_data | hit_stat);
    assign ack  = (state_q == DONE);
    assign busy = sel & ~ack;

    // Strobes and bus enable decode straight from the state register so that
    // an asynchronous reset releases them in the same instant it hits.
    assign rdn     = (state_q != RD_LOW);
    assign wrn     = (state_q != WR_LOW);
    assign bus_oe  = (state_q == WR_SETUP) | (state_q == WR_LOW) | (state_q == WR_HOLD);
    assign rdata   = rdata_q;
    assign bus_out = bus_out_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= 16'h0000;
            bus_out_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_out_q <= bus_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        bus_out_d = bus_out_q;

        case (state_q)
            IDLE: begin
                if (sel) begin
                    // Write wins when both requests are raised together.
                    if (req_write) begin
                        if (hit_data) begin
                            // Byte captured at accept so it is already stable
                            // on the bus for the whole WR_SETUP cycle.
                            bus_out_d = wdata[7:0];
                            state_d   = WR_SETUP;
                        end else begin
                            state_d = DONE;
                        end
                    end else if (hit_data) begin
                        state_d = RD_WAIT;
                    end else begin
                        state_d = STAT;
                    end
                end
            end
            STAT: begin
                rdata_d = {14'b0, data_ready, tbre & tsre};
                state_d = DONE;
            end
            RD_WAIT: begin
                if (data_ready) begin
                    cnt_d   = CNT_W'(RD_HOLD - 1);
                    state_d = RD_LOW;
                end
            end
            RD_LOW: begin
                if (cnt_q == '0) begin
                    rdata_d = {8'h00, bus_in};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                cnt_d   = CNT_W'(WR_PULSE - 1);
                state_d = WR_LOW;
            end
            WR_LOW: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: state_d = WR_TBRE;
            WR_TBRE: if (tbre) state_d = WR_TSRE;
            WR_TSRE: if (tsre) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_port_ctrl.sv
// tb/tb_uart_port_ctrl.sv - scoreboard bench for uart_port_ctrl with randomized accesses
module tb_uart_port_ctrl;

    localparam logic [15:0] DATA_ADDR = 16'hBF00;
    localparam logic [15:0] STAT_ADDR = 16'hBF01;
    localparam int          RD_HOLD   = 2;
    localparam int          WR_PULSE  = 2;

    localparam int K_STAT_RD = 0;
    localparam int K_DATA_RD = 1;
    localparam int K_DATA_WR = 2;
    localparam int K_STAT_WR = 3;

    logic        CLK, RST;
    logic        req_read, req_write;
    logic [15:0] addr, wdata;
    logic        sel, ack, busy;
    logic [15:0] rdata;
    logic [7:0]  bus_in, bus_out;
    logic        bus_oe, data_ready, tbre, tsre, rdn, wrn;

    uart_port_ctrl #(
        .DATA_ADDR(DATA_ADDR), .STAT_ADDR(STAT_ADDR), .RD_HOLD(RD_HOLD), .WR_PULSE(WR_PULSE)
    ) dut (
        .CLK(CLK), .RST(RST), .req_read(req_read), .req_write(req_write),
        .addr(addr), .wdata(wdata), .sel(sel), .ack(ack), .rdata(rdata), .busy(busy),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .data_ready(data_ready),
        .tbre(tbre), .tsre(tsre), .rdn(rdn), .wrn(wrn)
    );

    typedef struct {
        int          kind;
        logic [15:0] rdata;
        logic [7:0]  wbyte;
        int          rd_low;
        int          wr_low;
        int          oe_len;
        int          req_cyc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          viol  = 0;
    logic [15:0] model_rdata = 16'h0000;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts strobe/enable cycles per transaction and scores on ack.
    initial begin
        exp_t       e;
        int         rd_cnt, wr_cnt, oe_cnt;
        logic [7:0] wb_seen;
        rd_cnt = 0; wr_cnt = 0; oe_cnt = 0; wb_seen = 8'h00;
        forever begin
            @(negedge CLK);
            if (RST) begin
                rd_cnt = 0; wr_cnt = 0; oe_cnt = 0;
            end else begin
                if (!rdn) rd_cnt++;
                if (bus_oe) oe_cnt++;
                if (!wrn) begin
                    wr_cnt++;
                    wb_seen = bus_out;
                    if (!bus_oe) viol++;
                end
                if (!rdn && !wrn) viol++;
                if (bus_oe && !rdn) viol++;
                if (ack) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rdata", rdata, e.rdata);
                        chk("rdn_low_cycles", rd_cnt, e.rd_low);
                        chk("wrn_low_cycles", wr_cnt, e.wr_low);
                        chk("bus_oe_cycles", oe_cnt, e.oe_len);
                        if (e.lat >= 0) chk("latency", cyc - e.req_cyc, e.lat);
                        if (e.kind == K_DATA_WR) begin
                            chk("bus_out_byte", wb_seen, e.wbyte);
                            chk("tx_empty_at_ack", {tbre, tsre}, 2'b11);
                        end
                    end
                    rd_cnt = 0; wr_cnt = 0; oe_cnt = 0;
                end
            end
        end
    end

    task automatic wait_wrn(input logic level, output bit ok);
        int n = 0;
        while (wrn !== level && n < 50) begin
            @(negedge CLK);
            n++;
        end
        ok = (wrn === level);
    endtask

    // One access. d: data_ready delay (reads) or tbre delay (writes); d2: tsre delay.
    task automatic access(input int kind, input logic [15:0] wd, input int d, input int d2,
                          input bit both, input logic [2:0] env, input logic [7:0] bin);
        exp_t e;
        int   n;
        bit   ok;
        @(negedge CLK);
        e.kind = kind; e.req_cyc = cyc; e.lat = -1;
        e.rd_low = 0; e.wr_low = 0; e.oe_len = 0; e.wbyte = 8'h00;
        wdata = wd;
        case (kind)
            K_STAT_RD: begin
                {data_ready, tbre, tsre} = env;
                model_rdata = {14'b0, env[2], env[1] & env[0]};
                e.lat = 2;
                addr = STAT_ADDR; req_read = 1'b1;
            end
            K_DATA_RD: begin
                bus_in = bin;
                data_ready = (d == 0);
                model_rdata = {8'h00, bin};
                e.rd_low = RD_HOLD;
                e.lat = ((d < 1) ? 1 : d) + RD_HOLD + 1;
                addr = DATA_ADDR; req_read = 1'b1;
            end
            K_DATA_WR: begin
                tbre = 1'b0; tsre = 1'b0;
                e.wbyte = wd[7:0];
                e.wr_low = WR_PULSE;
                e.oe_len = WR_PULSE + 2;
                addr = DATA_ADDR; req_write = 1'b1; req_read = both;
            end
            default: begin
                e.lat = 1;
                addr = STAT_ADDR; req_write = 1'b1; req_read = both;
            end
        endcase
        e.rdata = model_rdata;
        sb.push_back(e);
        #1;
        chk("sel_on_req", sel, 1'b1);
        chk("busy_on_req", busy, 1'b1);
        if (kind == K_DATA_RD && d > 0) begin
            repeat (d) @(negedge CLK);
            data_ready = 1'b1;
        end
        if (kind == K_DATA_WR) begin
            wait_wrn(1'b0, ok);
            if (!ok) chk("wrn_fall_timeout", 32'd0, 32'd1);
            wait_wrn(1'b1, ok);
            if (!ok) chk("wrn_rise_timeout", 32'd0, 32'd1);
            repeat (d) @(negedge CLK);
            tbre = 1'b1;
            repeat (d2) @(negedge CLK);
            tsre = 1'b1;
        end
        n = 0;
        while (!ack && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!ack) begin
            chk("ack_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        req_read = 1'b0; req_write = 1'b0;
    endtask

    initial begin
        bit ok, quiet;
        RST = 1'b1; req_read = 1'b0; req_write = 1'b0; addr = 16'h0000; wdata = 16'h0000;
        bus_in = 8'h00; data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_rdn", rdn, 1'b1);
        chk("rst_wrn", wrn, 1'b1);
        chk("rst_bus_oe", bus_oe, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_bus_out", bus_out, 8'h00);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_sel", sel, 1'b0);
        chk("rst_busy", busy, 1'b0);
        RST = 1'b0;

        access(K_STAT_RD, 16'h0, 0, 0, 1'b0, 3'b111, 8'h00);
        access(K_DATA_RD, 16'h0, 5, 0, 1'b0, 3'b000, 8'hA5);
        access(K_DATA_WR, 16'h1234, 4, 2, 1'b0, 3'b000, 8'h00);
        access(K_DATA_WR, 16'hBEEF, 1, 0, 1'b1, 3'b000, 8'h00);
        access(K_STAT_WR, 16'h5555, 0, 0, 1'b0, 3'b000, 8'h00);
        access(K_STAT_RD, 16'h0, 0, 0, 1'b0, 3'b101, 8'h00);
        access(K_DATA_RD, 16'h0, 0, 0, 1'b0, 3'b000, 8'h00);

        // Unmapped address must be ignored entirely.
        @(negedge CLK);
        addr = 16'h8000; req_read = 1'b1;
        #1;
        chk("unmapped_sel", sel, 1'b0);
        chk("unmapped_busy", busy, 1'b0);
        quiet = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            if (!rdn || !wrn || bus_oe || ack) quiet = 1'b0;
        end
        chk("unmapped_quiet", quiet, 1'b1);
        req_read = 1'b0;

        // Reset in the middle of the write strobe.
        @(negedge CLK);
        addr = DATA_ADDR; wdata = 16'h00C3; tbre = 1'b0; tsre = 1'b0; req_write = 1'b1;
        wait_wrn(1'b0, ok);
        chk("rst_mid_wr_reached_wrlow", ok, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_wr_wrn", wrn, 1'b1);
        chk("rst_mid_wr_bus_oe", bus_oe, 1'b0);
        chk("rst_mid_wr_rdn", rdn, 1'b1);
        req_write = 1'b0;
        model_rdata = 16'h0000;
        @(negedge CLK);
        chk("rst_mid_wr_rdata", rdata, 16'h0000);
        chk("rst_mid_wr_bus_out", bus_out, 8'h00);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        access(K_DATA_RD, 16'h0, 0, 0, 1'b0, 3'b000, 8'h3C);

        for (int i = 0; i < 40; i++) begin
            access(int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 4)), 1'($urandom), 3'($urandom), 8'($urandom));
        end

        repeat (3) @(negedge CLK);
        chk("pending_expectations", sb.size(), 0);
        chk("protocol_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
